// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared encodings and helpers for the SDRAM command responder
// Purpose: command codes ({cs,ras,cas,we}), sticky error bit indices,
//          mode-word field positions and small data helpers.
package sdram_pkg;

  typedef enum logic [3:0] {
    CMD_LOAD_MODE = 4'b0000,
    CMD_REFRESH   = 4'b0001,
    CMD_PRECHARGE = 4'b0010,
    CMD_ACTIVE    = 4'b0011,
    CMD_WRITE     = 4'b0100,
    CMD_READ      = 4'b0101,
    CMD_BST       = 4'b0110,
    CMD_NOP       = 4'b0111
  } sdram_cmd_e;

  localparam int ERR_NO_MODE = 0;  // command before a legal mode word
  localparam int ERR_CLOSED  = 1;  // access to a closed bank
  localparam int ERR_RCD     = 2;  // access before tRCD expired
  localparam int ERR_OPEN    = 3;  // ACTIVE on open bank / REFRESH with open bank
  localparam int ERR_MODE    = 4;  // illegal mode word

  localparam int MODE_CL_LSB = 4;
  localparam int MODE_CL_MSB = 6;
  localparam int MODE_BL_LSB = 0;
  localparam int MODE_BL_MSB = 2;
  localparam int ADDR_AP_BIT = 10;

  // Masked bytes read back as zero.
  function automatic logic [15:0] mask_bytes(input logic [15:0] data, input logic [1:0] dqm);
    return {dqm[1] ? 8'h00 : data[15:8], dqm[0] ? 8'h00 : data[7:0]};
  endfunction

  // Only CL 2/3 with single-beat bursts are supported.
  function automatic logic mode_word_ok(input logic [2:0] cl, input logic [2:0] bl);
    return ((cl == 3'd2) || (cl == 3'd3)) && (bl == 3'b000);
  endfunction

endpackage

// File: rtl/sdram_resp_mem.sv
// rtl/sdram_resp_mem.sv - backing array for the SDRAM responder
// Purpose: single-clock 16-bit array, byte-enable write, registered read.
// Ports: clk; we/be/wdata write port; re/rdata read port; addr shared.
module sdram_resp_mem #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          we,
  input  logic [1:0]    be,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem_q [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      if (be[0]) mem_q[addr][7:0]  <= wdata[7:0];
      if (be[1]) mem_q[addr][15:8] <= wdata[15:8];
    end
    if (re) rdata <= mem_q[addr];
  end

endmodule

// File: rtl/sdram_responder.sv
// rtl/sdram_responder.sv - behavioural SDRAM device model with protocol checking
// Purpose: decodes SDRAM commands, tracks bank/row state and tRCD, serves
//          reads with CAS latency 2 or 3, flags protocol errors.
// Ports: clk, reset_n (async low); sd_cs/ras/cas/we, sd_addr, sd_ba, sd_dqm,
//        dq_in command side; dq_out/dq_oe read data; mode_valid, err,
//        refresh_cnt status.
module sdram_responder import sdram_pkg::*; #(
  parameter int ROW_BITS = 3,
  parameter int COL_BITS = 9,
  parameter int RCD      = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sd_cs,
  input  logic        sd_ras,
  input  logic        sd_cas,
  input  logic        sd_we,
  input  logic [12:0] sd_addr,
  input  logic [1:0]  sd_ba,
  input  logic [1:0]  sd_dqm,
  input  logic [15:0] dq_in,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  output logic        mode_valid,
  output logic [4:0]  err,
  output logic [15:0] refresh_cnt
);

  localparam int AW = 2 + ROW_BITS + COL_BITS;
  localparam int CW = (RCD > 1) ? $clog2(RCD) : 1;
  // Loaded with RCD-1 so the counter reads zero exactly RCD edges after ACTIVE.
  localparam logic [CW-1:0] RCD_LOAD = CW'(RCD - 1);

  logic [3:0] cmd;
  assign cmd = {sd_cs, sd_ras, sd_cas, sd_we};

  // sd_cs=1 never matches any 0xxx code, so INHIBIT falls out as a no-op.
  logic is_lm, is_act, is_rd, is_wr, is_pre, is_ref, is_nop;
  assign is_lm  = (cmd == CMD_LOAD_MODE);
  assign is_act = (cmd == CMD_ACTIVE);
  assign is_rd  = (cmd == CMD_READ);
  assign is_wr  = (cmd == CMD_WRITE);
  assign is_pre = (cmd == CMD_PRECHARGE);
  assign is_ref = (cmd == CMD_REFRESH);
  assign is_nop = (cmd == CMD_NOP);

  logic                          mode_valid_q, mode_valid_d, cl3_q, cl3_d;
  logic [4:0]                    err_q, err_d;
  logic [15:0]                   refresh_q, refresh_d;
  logic [3:0]                    open_q, open_d;
  logic [3:0][ROW_BITS-1:0]      row_q, row_d;
  logic [3:0][CW-1:0]            rcd_q, rcd_d;

  logic bank_open, acc, mode_ok;
  logic [2:0] mw_cl;
  assign mw_cl     = sd_addr[MODE_CL_MSB:MODE_CL_LSB];
  assign mode_ok   = mode_word_ok(mw_cl, sd_addr[MODE_BL_MSB:MODE_BL_LSB]);
  assign bank_open = open_q[sd_ba];
  assign acc       = (is_rd || is_wr) && bank_open;

  logic unused_addr;
  assign unused_addr = ^sd_addr;

  always_comb begin
    mode_valid_d = mode_valid_q;
    cl3_d        = cl3_q;
    err_d        = err_q;
    open_d       = open_q;
    row_d        = row_q;
    refresh_d    = refresh_q + 16'(is_ref);
    for (int b = 0; b < 4; b++) begin
      rcd_d[b] = (rcd_q[b] != '0) ? rcd_q[b] - 1'b1 : rcd_q[b];
    end
    if (is_lm) begin
      if (mode_ok) begin
        mode_valid_d = 1'b1;
        cl3_d        = mw_cl[0];
      end else begin
        err_d[ERR_MODE] = 1'b1;
      end
    end
    if (is_act) begin
      open_d[sd_ba] = 1'b1;
      row_d[sd_ba]  = sd_addr[ROW_BITS-1:0];
      rcd_d[sd_ba]  = RCD_LOAD;
    end
    if (acc && sd_addr[ADDR_AP_BIT]) open_d[sd_ba] = 1'b0;
    if (is_pre) begin
      if (sd_addr[ADDR_AP_BIT]) open_d = '0;
      else                      open_d[sd_ba] = 1'b0;
    end
    if (!mode_valid_q && !sd_cs && !(is_pre || is_lm || is_nop)) err_d[ERR_NO_MODE] = 1'b1;
    if ((is_rd || is_wr) && !bank_open)                           err_d[ERR_CLOSED]  = 1'b1;
    if (acc && (rcd_q[sd_ba] != '0))                              err_d[ERR_RCD]     = 1'b1;
    if ((is_act && bank_open) || (is_ref && (open_q != '0)))      err_d[ERR_OPEN]    = 1'b1;
  end

  logic [15:0] rd_data;
  sdram_resp_mem #(.AW(AW)) u_mem (
    .clk   (clk),
    .we    (acc && is_wr),
    .be    (~sd_dqm),
    .re    (acc && is_rd),
    .addr  ({sd_ba, row_q[sd_ba], sd_addr[COL_BITS-1:0]}),
    .wdata (dq_in),
    .rdata (rd_data)
  );

  // Read pipe: s1 aligns with the registered array output, s2 holds masked
  // data (emitted next edge for CL2), s3 adds the extra stage for CL3.
  logic        s1_vld_q, s1_cl3_q, s2_vld_q, s2_cl3_q, s3_vld_q, dq_oe_q;
  logic [1:0]  s1_mask_q;
  logic [15:0] s2_data_q, s3_data_q, dq_out_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_valid_q <= 1'b0;
      cl3_q        <= 1'b1;
      err_q        <= '0;
      refresh_q    <= '0;
      open_q       <= '0;
      row_q        <= '0;
      rcd_q        <= '0;
      s1_vld_q     <= 1'b0;
      s1_cl3_q     <= 1'b0;
      s1_mask_q    <= '0;
      s2_vld_q     <= 1'b0;
      s2_cl3_q     <= 1'b0;
      s2_data_q    <= '0;
      s3_vld_q     <= 1'b0;
      s3_data_q    <= '0;
      dq_oe_q      <= 1'b0;
      dq_out_q     <= '0;
    end else begin
      mode_valid_q <= mode_valid_d;
      cl3_q        <= cl3_d;
      err_q        <= err_d;
      refresh_q    <= refresh_d;
      open_q       <= open_d;
      row_q        <= row_d;
      rcd_q        <= rcd_d;
      s1_vld_q     <= acc && is_rd;
      s1_cl3_q     <= cl3_q;
      s1_mask_q    <= sd_dqm;
      s2_vld_q     <= s1_vld_q;
      s2_cl3_q     <= s1_cl3_q;
      s2_data_q    <= mask_bytes(rd_data, s1_mask_q);
      s3_vld_q     <= s2_vld_q && s2_cl3_q;
      s3_data_q    <= s2_data_q;
      if (s2_vld_q && !s2_cl3_q) begin
        dq_oe_q  <= 1'b1;
        dq_out_q <= s2_data_q;
      end else if (s3_vld_q) begin
        dq_oe_q  <= 1'b1;
        dq_out_q <= s3_data_q;
      end else begin
        dq_oe_q  <= 1'b0;
        dq_out_q <= '0;
      end
    end
  end

  assign dq_out      = dq_out_q;
  assign dq_oe       = dq_oe_q;
  assign mode_valid  = mode_valid_q;
  assign err         = err_q;
  assign refresh_cnt = refresh_q;

endmodule

// File: tb/tb_sdram_responder.sv
// tb/tb_sdram_responder.sv - directed self-checking bench for sdram_responder
module tb_sdram_responder;
  import sdram_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sd_cs = 1'b1, sd_ras = 1'b1, sd_cas = 1'b1, sd_we = 1'b1;
  logic [12:0] sd_addr = '0;
  logic [1:0]  sd_ba = '0, sd_dqm = '0;
  logic [15:0] dq_in = '0;
  logic [15:0] dq_out;
  logic        dq_oe, mode_valid;
  logic [4:0]  err;
  logic [15:0] refresh_cnt;

  sdram_responder dut (
    .clk(clk), .reset_n(reset_n), .sd_cs(sd_cs), .sd_ras(sd_ras), .sd_cas(sd_cas),
    .sd_we(sd_we), .sd_addr(sd_addr), .sd_ba(sd_ba), .sd_dqm(sd_dqm), .dq_in(dq_in),
    .dq_out(dq_out), .dq_oe(dq_oe), .mode_valid(mode_valid), .err(err),
    .refresh_cnt(refresh_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Every cycle with dq_oe high is logged with the edge count it followed.
  int          oe_cyc[$];
  logic [15:0] oe_dat[$];
  always @(negedge clk) begin
    if (dq_oe) begin
      oe_cyc.push_back(cyc);
      oe_dat.push_back(dq_out);
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int last_edge = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                       input logic [1:0] m, input logic [15:0] d);
    @(negedge clk);
    {sd_cs, sd_ras, sd_cas, sd_we} = c;
    sd_ba = ba; sd_addr = a; sd_dqm = m; dq_in = d;
    last_edge = cyc + 1;
  endtask

  task automatic nop(input int n);
    repeat (n) issue(CMD_NOP, 2'd0, 13'd0, 2'd0, 16'd0);
  endtask

  task automatic clear_log();
    oe_cyc.delete();
    oe_dat.delete();
  endtask

  task automatic got_read(input int idx, input string tag, input int exp_cyc, input logic [15:0] exp_dat);
    int          c;
    logic [15:0] d;
    c = (idx < oe_cyc.size()) ? oe_cyc[idx] : -1;
    d = (idx < oe_dat.size()) ? oe_dat[idx] : 16'hDEAD;
    chk({tag, "_cycle"}, c, exp_cyc);
    chk({tag, "_data"}, d, exp_dat);
  endtask

  int e0, e1;

  initial begin
    // reset state
    nop(3);
    chk("rst_oe", dq_oe, 1'b0);
    chk("rst_dout", dq_out, 16'h0);
    chk("rst_mode", mode_valid, 1'b0);
    chk("rst_err", err, 5'h0);
    chk("rst_refresh", refresh_cnt, 16'h0);
    reset_n = 1'b1;

    // INHIBIT carrying a bad LOAD_MODE pattern is ignored
    issue(4'b1000, 2'd0, 13'h0031, 2'd0, 16'd0); nop(1);
    chk("inhibit_err", err, 5'h0);

    // init: CL=3
    issue(CMD_PRECHARGE, 2'd0, 13'h0400, 2'd0, 16'd0);
    issue(CMD_LOAD_MODE, 2'd0, 13'h0230, 2'd0, 16'd0); nop(1);
    chk("init_mode", mode_valid, 1'b1);
    chk("init_err", err, 5'h0);

    // masked write then CL3 read
    issue(CMD_ACTIVE, 2'd1, 13'd5, 2'd0, 16'd0); nop(1);
    issue(CMD_WRITE, 2'd1, 13'd9, 2'b00, 16'h0000);
    issue(CMD_WRITE, 2'd1, 13'h0409, 2'b01, 16'hA55A);
    issue(CMD_ACTIVE, 2'd1, 13'd5, 2'd0, 16'd0); nop(1);
    clear_log();
    issue(CMD_READ, 2'd1, 13'd9, 2'b00, 16'd0); e0 = last_edge;
    nop(6);
    chk("cl3_count", oe_cyc.size(), 1);
    got_read(0, "cl3", e0 + 3, 16'hA500);
    chk("cl3_err", err, 5'h0);

    // CL=2, four back-to-back reads
    issue(CMD_LOAD_MODE, 2'd0, 13'h0020, 2'd0, 16'd0);
    for (int i = 0; i < 4; i++) issue(CMD_WRITE, 2'd1, 13'(i), 2'b00, 16'(i + 1));
    issue(CMD_WRITE, 2'd1, 13'd4, 2'b00, 16'hFFFF);
    nop(1);
    clear_log();
    for (int i = 0; i < 4; i++) begin
      issue(CMD_READ, 2'd1, 13'(i), 2'b00, 16'd0);
      if (i == 0) e0 = last_edge;
    end
    nop(6);
    chk("b2b_count", oe_cyc.size(), 4);
    for (int i = 0; i < 4; i++) got_read(i, $sformatf("b2b%0d", i), e0 + 2 + i, 16'(i + 1));

    // read-side byte mask, and a write behind an in-flight read
    clear_log();
    issue(CMD_READ, 2'd1, 13'd4, 2'b10, 16'd0); e0 = last_edge;
    issue(CMD_WRITE, 2'd1, 13'd4, 2'b00, 16'h0000); nop(1);
    issue(CMD_READ, 2'd1, 13'd4, 2'b00, 16'd0); e1 = last_edge;
    nop(5);
    chk("mask_count", oe_cyc.size(), 2);
    got_read(0, "mask", e0 + 2, 16'h00FF);
    got_read(1, "overwrite", e1 + 2, 16'h0000);
    issue(CMD_BST, 2'd0, 13'd0, 2'd0, 16'd0); nop(1);
    chk("bst_err", err, 5'h0);

    // tRCD violation, then read to a closed bank
    issue(CMD_ACTIVE, 2'd2, 13'd1, 2'd0, 16'd0);
    issue(CMD_READ, 2'd2, 13'd0, 2'd0, 16'd0); nop(1);
    chk("rcd_err", err, 5'b00100);
    nop(5);
    clear_log();
    issue(CMD_READ, 2'd3, 13'd0, 2'd0, 16'd0); nop(6);
    chk("closed_err", err, 5'b00110);
    chk("closed_no_oe", oe_cyc.size(), 0);

    // refresh counter wrap and refresh-while-open
    issue(CMD_PRECHARGE, 2'd0, 13'h0400, 2'd0, 16'd0);
    repeat (65537) issue(CMD_REFRESH, 2'd0, 13'd0, 2'd0, 16'd0);
    nop(1);
    chk("ref_wrap", refresh_cnt, 16'd1);
    chk("ref_wrap_err", err, 5'b00110);
    issue(CMD_ACTIVE, 2'd1, 13'd5, 2'd0, 16'd0);
    issue(CMD_REFRESH, 2'd0, 13'd0, 2'd0, 16'd0); nop(1);
    chk("ref_open_err", err, 5'b01110);
    chk("ref_open_cnt", refresh_cnt, 16'd2);

    // illegal mode word keeps CL=2
    issue(CMD_LOAD_MODE, 2'd0, 13'h0031, 2'd0, 16'd0); nop(1);
    chk("badmode_err", err, 5'b11110);
    chk("badmode_valid", mode_valid, 1'b1);
    clear_log();
    issue(CMD_READ, 2'd1, 13'd0, 2'b00, 16'd0); e0 = last_edge;
    nop(5);
    got_read(0, "keep_cl2", e0 + 2, 16'd1);

    // reset one cycle after a read
    clear_log();
    issue(CMD_READ, 2'd1, 13'd1, 2'b00, 16'd0);
    nop(1); reset_n = 1'b0;
    nop(1); reset_n = 1'b1;
    nop(6);
    chk("rst_flight_no_oe", oe_cyc.size(), 0);
    chk("rst2_mode", mode_valid, 1'b0);
    chk("rst2_err", err, 5'h0);
    chk("rst2_refresh", refresh_cnt, 16'h0);

    // command before mode set, then the array survives reset
    issue(CMD_REFRESH, 2'd0, 13'd0, 2'd0, 16'd0); nop(1);
    chk("nomode_err", err, 5'b00001);
    chk("nomode_refresh", refresh_cnt, 16'd1);
    issue(CMD_PRECHARGE, 2'd0, 13'h0400, 2'd0, 16'd0);
    issue(CMD_LOAD_MODE, 2'd0, 13'h0230, 2'd0, 16'd0);
    issue(CMD_ACTIVE, 2'd1, 13'd5, 2'd0, 16'd0); nop(1);
    clear_log();
    issue(CMD_READ, 2'd1, 13'd9, 2'b00, 16'd0); e0 = last_edge;
    nop(6);
    chk("post_rst_count", oe_cyc.size(), 1);
    got_read(0, "post_rst", e0 + 3, 16'hA500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
